// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encodings and bit-timing helpers, common to TX and RX.
`ifndef FCLK
`define FCLK 1_600_000
`endif

package uart_tx_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  function automatic int nticks(input int fclk, input int bauds);
    return fclk / bauds;
  endfunction

  function automatic int wframe(input int wdata, input int wstop);
`ifdef UART_TX_PARITY_EN
    return 2 + wdata + wstop;
`else
    return 1 + wdata + wstop;
`endif
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Depth x Wdata word queue with registered occupancy count; full/empty derive from the count only.
module uart_tx_fifo #(
  parameter int Wdata = 8,
  parameter int Depth = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [Wdata-1:0] i_dat,
  input  logic             i_pop,
  output logic [Wdata-1:0] o_dat,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(Depth);
  localparam int CW = AW + 1;

  logic [Wdata-1:0] r_mem [Depth];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_cnt;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_cnt == CW'(Depth));
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_dat   = r_mem[r_rd];

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= i_dat;
  end

  // Depth is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional even parity (UART_TX_PARITY_EN), stop bits.
// TXD is registered from the FSM state, so the line trails the state by one clock.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int Bauds = 100_000,
  parameter int Wdata = 8,
  parameter int Wstop = 1,
  parameter int Depth = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [Wdata-1:0] DIN,
  input  logic             STB,
  output logic             RDY,
  output logic             TXD,
  output logic             BUSY,
  output logic             INT
);

  localparam int NTICKS = nticks(`FCLK, Bauds);
  localparam int TW     = $clog2(NTICKS);
  localparam int BW     = $clog2((Wdata > Wstop) ? Wdata : Wstop);
  localparam logic [TW-1:0] TICK_LAST = TW'(NTICKS - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(Wdata - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(Wstop - 1);

  logic [2:0]       r_state;
  logic [TW-1:0]    r_tick;
  logic [BW-1:0]    r_bit;
  logic [Wdata-1:0] r_shift;
  logic             r_txd;
  logic             r_busy;
  logic             r_int;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic [Wdata-1:0] w_head;
  logic             w_tick_done;
  logic             w_stop_done;
  logic             w_txd_nxt;
`ifdef UART_TX_PARITY_EN
  logic             r_par;
`endif

  uart_tx_fifo #(.Wdata(Wdata), .Depth(Depth)) u_fifo (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_push  (STB),
    .i_dat   (DIN),
    .i_pop   (w_pop),
    .o_dat   (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_tick_done = (r_tick == '0);
  assign w_stop_done = (r_state == S_STOP) && w_tick_done && (r_bit == STOP_LAST);
  // Pop on idle, or straight out of the last stop bit so frames run without a gap.
  assign w_pop       = !w_empty && ((r_state == S_IDLE) || w_stop_done);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_tick  <= TICK_LAST;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      if (r_state != S_IDLE) r_tick <= w_tick_done ? TICK_LAST : r_tick - TW'(1);
      if (w_pop) begin
        r_state <= S_START;
        r_tick  <= TICK_LAST;
        r_shift <= w_head;
      end else if (w_tick_done) begin
        case (r_state)
          S_START: begin
            r_state <= S_DATA;
            r_bit   <= '0;
          end
          S_DATA: begin
            r_shift <= r_shift >> 1;
            if (r_bit == DATA_LAST) begin
              r_bit   <= '0;
`ifdef UART_TX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end else begin
              r_bit <= r_bit + BW'(1);
            end
          end
`ifdef UART_TX_PARITY_EN
          S_PARITY: begin
            r_state <= S_STOP;
            r_bit   <= '0;
          end
`endif
          S_STOP: begin
            if (r_bit == STOP_LAST) r_state <= S_IDLE;
            else                    r_bit   <= r_bit + BW'(1);
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)        r_par <= 1'b0;
    else if (w_pop) r_par <= ^w_head;
  end
`endif

  always_comb begin
    w_txd_nxt = 1'b1;
    case (r_state)
      S_START:  w_txd_nxt = 1'b0;
      S_DATA:   w_txd_nxt = r_shift[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_txd_nxt = r_par;
`endif
      default:  w_txd_nxt = 1'b1;
    endcase
  end

  // BUSY and INT are delayed with TXD so they line up with the line itself.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_txd  <= 1'b1;
      r_busy <= 1'b0;
      r_int  <= 1'b0;
    end else begin
      r_txd  <= w_txd_nxt;
      r_busy <= (r_state != S_IDLE) || !w_empty;
      r_int  <= w_stop_done;
    end
  end

  assign RDY  = !w_full;
  assign TXD  = r_txd;
  assign BUSY = r_busy;
  assign INT  = r_int;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 16 clocks per bit, 8 data bits, 1 stop bit, depth 4.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int NT = 16;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] DIN;
  logic       STB;
  logic       RDY;
  logic       TXD;
  logic       BUSY;
  logic       int_o;

  int checks = 0;
  int errors = 0;

  uart_tx #(.Bauds(100_000), .Wdata(8), .Wstop(1), .Depth(4)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .DIN  (DIN),
    .STB  (STB),
    .RDY  (RDY),
    .TXD  (TXD),
    .BUSY (BUSY),
    .INT  (int_o)
  );

  always #5 CLK = ~CLK;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Word is accepted on the edge inside this task; DIN is scrambled afterwards.
  task automatic write(input logic [7:0] d);
    DIN = d;
    STB = 1'b1;
    step(1);
    STB = 1'b0;
    DIN = ~d;
  endtask

  task automatic wait_start(input string name);
    int n;
    n = 0;
    while (TXD !== 1'b0 && n < 2000) begin
      step(1);
      n++;
    end
    checks++;
    if (TXD !== 1'b0) begin
      errors++;
      $display("FAIL %s start-bit timeout: TXD=%b, required 0", name, TXD);
    end
  endtask

  // Starts on the first clock of the start bit; ends on the clock after the last stop cycle.
  task automatic check_frame(input logic [7:0] d, input string name);
    logic [NBITS-1:0] e;
    logic bad;
    logic badv;
    int   ints;
    int   ipos;
    e      = '1;
    e[0]   = 1'b0;
    e[8:1] = d;
`ifdef UART_TX_PARITY_EN
    e[9]   = ^d;
`endif
    ints = 0;
    ipos = -1;
    checks++;
    if (BUSY !== 1'b1) begin
      errors++;
      $display("FAIL %s busy: BUSY=%b, required 1", name, BUSY);
    end
    for (int b = 0; b < NBITS; b++) begin
      bad  = 1'b0;
      badv = 1'b0;
      for (int s = 0; s < NT; s++) begin
        if (TXD !== e[b] && !bad) begin
          bad  = 1'b1;
          badv = TXD;
        end
        if (int_o === 1'b1) begin
          ints++;
          ipos = b * NT + s;
        end
        step(1);
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL %s bit %0d: TXD=%b, required %b for %0d clocks", name, b, badv, e[b], NT);
      end
    end
    checks++;
    if (ints != 1 || ipos != NBITS * NT - 1) begin
      errors++;
      $display("FAIL %s int: %0d pulses at clock %0d, required 1 at clock %0d",
               name, ints, ipos, NBITS * NT - 1);
    end
  endtask

  task automatic test_reset;
    RST = 1'b1;
    STB = 1'b0;
    DIN = 8'h00;
    step(3);
    checks++;
    if ({TXD, RDY, BUSY, int_o} !== 4'b1100) begin
      errors++;
      $display("FAIL reset: TXD/RDY/BUSY/INT=%b, required 1100", {TXD, RDY, BUSY, int_o});
    end
    RST = 1'b0;
    step(2);
  endtask

  task automatic test_single;
    write(8'hA5);
    checks++;
    if (TXD !== 1'b1) begin
      errors++;
      $display("FAIL latency edge k: TXD=%b, required 1", TXD);
    end
    step(1);
    checks++;
    if (TXD !== 1'b1) begin
      errors++;
      $display("FAIL latency edge k+1: TXD=%b, required 1", TXD);
    end
    step(1);
    check_frame(8'hA5, "single_a5");
    checks++;
    if ({TXD, BUSY, int_o} !== 3'b100) begin
      errors++;
      $display("FAIL single idle: TXD/BUSY/INT=%b, required 100", {TXD, BUSY, int_o});
    end
  endtask

  task automatic test_back_to_back;
    DIN = 8'h00;
    STB = 1'b1;
    step(1);
    DIN = 8'hFF;
    step(1);
    STB = 1'b0;
    wait_start("b2b");
    check_frame(8'h00, "b2b_00");
    check_frame(8'hFF, "b2b_ff");
    checks++;
    if ({TXD, BUSY} !== 2'b10) begin
      errors++;
      $display("FAIL b2b idle: TXD/BUSY=%b, required 10", {TXD, BUSY});
    end
  endtask

  task automatic test_full;
    logic [7:0] w [5];
    int lows;
    w = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    fork
      begin
        write(8'hC3);
        for (int i = 0; i < 5; i++) begin
          checks++;
          if (RDY !== (i < 4)) begin
            errors++;
            $display("FAIL full rdy before word %0d: RDY=%b, required %b", i + 1, RDY, i < 4);
          end
          write(w[i]);
        end
      end
      begin
        wait_start("full");
        check_frame(8'hC3, "full_inflight");
        for (int i = 0; i < 4; i++) check_frame(w[i], "full_queued");
      end
    join
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      if (TXD !== 1'b1) lows++;
      step(1);
    end
    checks++;
    if (lows != 0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL full dropped word: %0d low clocks BUSY=%b, required 0 and 0", lows, BUSY);
    end
  endtask

  task automatic test_reset_mid;
    int bad;
    write(8'h3C);
    wait_start("rstmid");
    step(NT + NT + 5);
    checks++;
    if (TXD !== 1'b0) begin
      errors++;
      $display("FAIL rstmid precondition: TXD=%b, required 0", TXD);
    end
    RST = 1'b1;
    #1;
    checks++;
    if ({TXD, RDY, BUSY, int_o} !== 4'b1100) begin
      errors++;
      $display("FAIL rstmid async: TXD/RDY/BUSY/INT=%b, required 1100", {TXD, RDY, BUSY, int_o});
    end
    step(2);
    RST = 1'b0;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      if (TXD !== 1'b1 || int_o !== 1'b0) bad++;
      step(1);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rstmid quiet: %0d bad clocks, required 0", bad);
    end
    write(8'h5A);
    step(2);
    check_frame(8'h5A, "rstmid_after");
  endtask

  task automatic test_parity;
    write(8'h07);
    step(2);
    check_frame(8'h07, "parity_07");
    write(8'h03);
    step(2);
    check_frame(8'h03, "parity_03");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_reset_mid();
    test_parity();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
